// File: rtl/CorePack.sv
// rtl/CorePack.sv - shared types for the register-file write-back arbiter
package CorePack;

  typedef logic [63:0] data_t;
  typedef logic [4:0]  reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    data_t    data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - ALU and load-return write-back handshakes
interface rf_wb_arbiter_if;
  import CorePack::*;

  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  data_t    alu_data;
  logic     mem_valid;
  logic     mem_ready;
  reg_idx_t mem_rd;
  data_t    mem_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/rf_wb_scoreboard.sv
// rtl/rf_wb_scoreboard.sv - pending-write mask; a set on the same edge as a clear wins
module rf_wb_scoreboard
  import CorePack::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_valid,
  input  reg_idx_t    set_idx,
  input  logic        clr_valid,
  input  reg_idx_t    clr_idx,
  output logic [31:0] pend_mask
);

  logic [31:0] pend_d;
  logic [31:0] pend_q;

  always_comb begin
    pend_d = pend_q;
    if (clr_valid) pend_d[clr_idx] = 1'b0;
    if (set_valid) pend_d[set_idx] = 1'b1;
    // x0 never has a write in flight
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_mask = pend_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-back arbiter, output stage and scoreboard hookup
// RF_WB_BYPASS_EN adds decode forwarding and retires pending bits one edge earlier.
module rf_wb_arbiter
  import CorePack::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  rf_wb_arbiter_if.slave wb,
  input  logic        issue_valid,
  input  reg_idx_t    issue_rd,
  output logic [31:0] pend_mask,
  output logic        rf_we,
  output reg_idx_t    rf_waddr,
  output data_t       rf_wdata
`ifdef RF_WB_BYPASS_EN
  ,
  input  reg_idx_t    rs1_addr,
  input  reg_idx_t    rs2_addr,
  output logic        rs1_fwd,
  output logic        rs2_fwd,
  output data_t       fwd_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  wb_req_t    alu_req;
  wb_req_t    mem_req;
  wb_req_t    win;
  logic       starve;
  logic       alu_hs;
  logic       mem_hs;

  logic [3:0] wait_cnt_d, wait_cnt_q;
  logic       rf_we_d, rf_we_q;
  reg_idx_t   rf_waddr_d, rf_waddr_q;
  data_t      rf_wdata_d, rf_wdata_q;
  logic       clr_valid;
  reg_idx_t   clr_idx;

  always_comb begin
    alu_req.valid = wb.alu_valid;
    alu_req.rd    = wb.alu_rd;
    alu_req.data  = wb.alu_data;
    mem_req.valid = wb.mem_valid;
    mem_req.rd    = wb.mem_rd;
    mem_req.data  = wb.mem_data;

    // MEM has priority unless the ALU has waited STARVE_LIMIT cycles
    starve       = (wait_cnt_q == LIMIT);
    wb.mem_ready = mem_req.valid && !(starve && alu_req.valid);
    wb.alu_ready = alu_req.valid && (!mem_req.valid || starve);
    alu_hs       = wb.alu_ready;
    mem_hs       = wb.mem_ready;

    win.valid = alu_hs || mem_hs;
    win.rd    = alu_hs ? alu_req.rd   : mem_req.rd;
    win.data  = alu_hs ? alu_req.data : mem_req.data;

    wait_cnt_d = wait_cnt_q;
    if (!alu_req.valid || alu_hs) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rf_we_d    = win.valid && (win.rd != '0);
    rf_waddr_d = win.valid ? win.rd   : rf_waddr_q;
    rf_wdata_d = win.valid ? win.data : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_BYPASS_EN
  // The forward path covers the cycle in which the value is still in the output stage
  assign clr_valid = win.valid;
  assign clr_idx   = win.rd;
  assign rs1_fwd   = rf_we_q && (rf_waddr_q == rs1_addr) && (rs1_addr != '0);
  assign rs2_fwd   = rf_we_q && (rf_waddr_q == rs2_addr) && (rs2_addr != '0);
  assign fwd_data  = rf_wdata_q;
`else
  assign clr_valid = rf_we_q;
  assign clr_idx   = rf_waddr_q;
`endif

  rf_wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_idx   (issue_rd),
    .clr_valid (clr_valid),
    .clr_idx   (clr_idx),
    .pend_mask (pend_mask)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed bench for rf_wb_arbiter, with or without RF_WB_BYPASS_EN
module tb_rf_wb_arbiter;
  import CorePack::*;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  reg_idx_t    issue_rd;
  logic [31:0] pend_mask;
  logic        rf_we;
  reg_idx_t    rf_waddr;
  data_t       rf_wdata;
`ifdef RF_WB_BYPASS_EN
  reg_idx_t    rs1_addr;
  reg_idx_t    rs2_addr;
  logic        rs1_fwd;
  logic        rs2_fwd;
  data_t       fwd_data;
`endif

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter_if wb_if ();

  rf_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_if),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pend_mask   (pend_mask),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef RF_WB_BYPASS_EN
    ,
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_fwd     (rs1_fwd),
    .rs2_fwd     (rs2_fwd),
    .fwd_data    (fwd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                = 1'b1;
    issue_valid        = 1'b0;
    issue_rd           = '0;
    wb_if.alu_valid    = 1'b0;
    wb_if.alu_rd       = '0;
    wb_if.alu_data     = '0;
    wb_if.mem_valid    = 1'b0;
    wb_if.mem_rd       = '0;
    wb_if.mem_data     = '0;
`ifdef RF_WB_BYPASS_EN
    rs1_addr = '0;
    rs2_addr = '0;
`endif

    // reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", rf_wdata, 64'd0);
    check("rst_pend_mask", 64'(pend_mask), 64'd0);
    check("rst_alu_ready", 64'(wb_if.alu_ready), 64'd0);
    check("rst_mem_ready", 64'(wb_if.mem_ready), 64'd0);
`ifdef RF_WB_BYPASS_EN
    check("rst_rs1_fwd", 64'(rs1_fwd), 64'd0);
    check("rst_rs2_fwd", 64'(rs2_fwd), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ALU only, rd=5
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd5;
    wb_if.alu_data  = 64'hDEAD_BEEF;
    #1;
    check("alu_only_ready", 64'(wb_if.alu_ready), 64'd1);
    check("alu_only_mem_ready", 64'(wb_if.mem_ready), 64'd0);
    @(posedge clk); #1;
    check("alu_only_we", 64'(rf_we), 64'd1);
    check("alu_only_waddr", 64'(rf_waddr), 64'd5);
    check("alu_only_wdata", rf_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_we", 64'(rf_we), 64'd0);
    check("idle_waddr_hold", 64'(rf_waddr), 64'd5);
    check("idle_wdata_hold", rf_wdata, 64'hDEAD_BEEF);

    // both valid for 8 cycles: M,M,M,A,M,M,M,A
    @(negedge clk);
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd1;
    wb_if.alu_data  = 64'hA1;
    wb_if.mem_valid = 1'b1;
    wb_if.mem_rd    = 5'd2;
    wb_if.mem_data  = 64'hB2;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("starve_alu_ready[%0d]", i), 64'(wb_if.alu_ready), 64'((i % 4) == 3));
      check($sformatf("starve_mem_ready[%0d]", i), 64'(wb_if.mem_ready), 64'((i % 4) != 3));
      @(posedge clk); #1;
      check($sformatf("starve_waddr[%0d]", i), 64'(rf_waddr), ((i % 4) == 3) ? 64'd1 : 64'd2);
      check($sformatf("starve_we[%0d]", i), 64'(rf_we), 64'd1);
      @(negedge clk);
    end
    wb_if.alu_valid = 1'b0;
    wb_if.mem_valid = 1'b0;

    // issue rd=7, MEM write to rd=7 three cycles later
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    @(posedge clk); #1;
    check("issue7_set", 64'(pend_mask), 64'h80);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    check("issue7_hold1", 64'(pend_mask[7]), 64'd1);
    @(negedge clk);
    @(posedge clk); #1;
    check("issue7_hold2", 64'(pend_mask[7]), 64'd1);
    @(negedge clk);
    wb_if.mem_valid = 1'b1;
    wb_if.mem_rd    = 5'd7;
    wb_if.mem_data  = 64'h1234_5678_9ABC_DEF0;
`ifdef RF_WB_BYPASS_EN
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
`endif
    #1;
    check("mem7_ready", 64'(wb_if.mem_ready), 64'd1);
    @(posedge clk); #1;
    check("mem7_we", 64'(rf_we), 64'd1);
    check("mem7_wdata", rf_wdata, 64'h1234_5678_9ABC_DEF0);
`ifdef RF_WB_BYPASS_EN
    check("mem7_pend_cleared", 64'(pend_mask[7]), 64'd0);
    check("mem7_rs1_fwd", 64'(rs1_fwd), 64'd1);
    check("mem7_rs2_fwd", 64'(rs2_fwd), 64'd0);
    check("mem7_fwd_data", fwd_data, 64'h1234_5678_9ABC_DEF0);
`else
    check("mem7_pend_still_set", 64'(pend_mask[7]), 64'd1);
`endif
    @(negedge clk);
    wb_if.mem_valid = 1'b0;
    @(posedge clk); #1;
    check("mem7_pend_final", 64'(pend_mask), 64'd0);
    check("mem7_we_drop", 64'(rf_we), 64'd0);
`ifdef RF_WB_BYPASS_EN
    check("mem7_rs1_fwd_drop", 64'(rs1_fwd), 64'd0);
`endif

    // issue to x0 is ignored
    @(negedge clk);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    @(posedge clk); #1;
    check("issue_x0", 64'(pend_mask), 64'd0);

    // ALU write to x0 with rd=3 pending
    @(negedge clk);
    issue_rd = 5'd3;
    @(posedge clk); #1;
    check("issue3_set", 64'(pend_mask), 64'h8);
    @(negedge clk);
    issue_valid     = 1'b0;
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd0;
    wb_if.alu_data  = 64'h55;
    #1;
    check("x0_alu_ready", 64'(wb_if.alu_ready), 64'd1);
    @(posedge clk); #1;
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_waddr", 64'(rf_waddr), 64'd0);
    check("x0_wdata", rf_wdata, 64'h55);
    check("x0_pend", 64'(pend_mask), 64'h8);
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    @(posedge clk); #1;
    check("x0_pend_after", 64'(pend_mask), 64'h8);

    // same-edge issue and retire of rd=9
    @(negedge clk);
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    @(posedge clk); #1;
    check("issue9_set", 64'(pend_mask), 64'h208);
    @(negedge clk);
    wb_if.mem_valid = 1'b1;
    wb_if.mem_rd    = 5'd9;
    wb_if.mem_data  = 64'h99;
`ifdef RF_WB_BYPASS_EN
    issue_valid = 1'b1;
`else
    issue_valid = 1'b0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    wb_if.mem_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
    issue_valid = 1'b0;
`else
    issue_valid = 1'b1;
`endif
    @(posedge clk); #1;
    check("same_edge_pend9", 64'(pend_mask), 64'h208);
    @(negedge clk);
    issue_valid = 1'b0;
    @(posedge clk); #1;
    check("same_edge_pend9_hold", 64'(pend_mask), 64'h208);

    // reset mid-transfer drops the in-flight write
    @(negedge clk);
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd4;
    wb_if.alu_data  = 64'h44;
    @(posedge clk);
    #1;
    check("pre_rst_we", 64'(rf_we), 64'd1);
    @(negedge clk);
    rst             = 1'b1;
    wb_if.alu_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_pend", 64'(pend_mask), 64'd0);
    check("mid_rst_waddr", 64'(rf_waddr), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
